div_exe_unit: RTL and testbench
===============================

DIV_EXE_UNIT -- requirements
Module: div_exe_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, sets the operand and result width.
REQ-002 Parameter ROB_TAG_WIDTH, default 5, sets the ROB tag and ROB read pointer width.
REQ-003 Parameter PID_WIDTH, default 6, sets the physical destination register id width.
REQ-004 The block SHALL use one clock, clk (posedge); reset is asynchronous and active-low.
REQ-005 Ports:
  - clk  in  1  clock.
  - reset  in  1  asynchronous active-low reset (0 = reset).
  - iu_div_issue  in  1  issue unit presents a ready division this cycle.
  - div_ready  out  1  unit can accept an issue this cycle.
  - iss_rs_data  in  DATA_WIDTH  dividend.
  - iss_rt_data  in  DATA_WIDTH  divisor.
  - iss_rem_sel  in  1  1 = return remainder, 0 = return quotient.
  - iss_rob_tag  in  ROB_TAG_WIDTH  ROB tag of the issued instruction.
  - iss_rd_pid  in  PID_WIDTH  destination physical register.
  - iss_reg_wr  in  1  instruction writes rd.
  - cdb_flush  in  1  mispredict flush strobe.
  - cdb_rob_tag  in  ROB_TAG_WIDTH  tag of the flushing branch.
  - rob_r_ptr  in  ROB_TAG_WIDTH  ROB read pointer (oldest entry).
  - div_cdb_req  out  1  result pending, requests the CDB.
  - cdb_div_grant  in  1  CDB arbiter grant.
  - div_cdb_data  out  DATA_WIDTH  result.
  - div_cdb_rob_tag  out  ROB_TAG_WIDTH  result tag.
  - div_cdb_rd_pid  out  PID_WIDTH  result destination.
  - div_cdb_reg_wr  out  1  result register-write bit.

Function
REQ-006 States: IDLE, BUSY, DONE; the unit is non-pipelined and holds one instruction at most.
REQ-007 div_ready SHALL be 1 only in IDLE; the issue is accepted on a posedge where iu_div_issue=1, div_ready=1 and the incoming instruction is not flushed.
REQ-008 On accept: latch operands, tag, pid, reg_wr and rem_sel; clear the iteration counter; go to BUSY.
REQ-009 BUSY SHALL run unsigned restoring division at one quotient bit per cycle, MSB first, for exactly DATA_WIDTH cycles; the counter is clog2(DATA_WIDTH)+1 bits wide.
REQ-010 After the DATA_WIDTH-th BUSY cycle, go to DONE; div_cdb_req rises exactly DATA_WIDTH+1 edges after the accept edge.
REQ-011 In DONE, div_cdb_req=1 and all div_cdb_* outputs SHALL stay stable until a posedge with cdb_div_grant=1, which returns the unit to IDLE.
REQ-012 In IDLE and BUSY, div_cdb_req=0; cdb_div_grant is ignored outside DONE.
REQ-013 Divide by zero: quotient = all ones, remainder = dividend; latency is unchanged.
REQ-014 div_cdb_data = remainder if rem_sel=1, else quotient.
REQ-015 Flush test: an instruction is junior when (tag - rob_r_ptr) >= (cdb_rob_tag - rob_r_ptr), both differences taken modulo 2^ROB_TAG_WIDTH; equal tags count as junior.
REQ-016 When cdb_flush=1 and the held instruction (BUSY or DONE) is junior, the next state SHALL be IDLE and the result is dropped.
REQ-017 When cdb_flush=1 and the held instruction is senior, it is unaffected.
REQ-018 Flush priority: flush over grant; a junior DONE entry with grant and flush in the same cycle is dropped, and div_cdb_req is 0 next cycle.
REQ-019 An issue coincident with cdb_flush whose iss_rob_tag is junior SHALL NOT be accepted; the unit stays IDLE.
REQ-020 div_cdb_req SHALL never be 1 for a flushed instruction on the cycle after the flush edge.

Reset
REQ-021 While reset=0, asynchronously: state = IDLE; counter and all data registers = 0; div_ready = 1; div_cdb_req = 0; all div_cdb_* outputs = 0.
REQ-022 Reset asserted mid-operation SHALL discard the instruction; no request follows the deassertion.
REQ-023 The first accept is permitted on the first posedge after reset deasserts.

Verification
REQ-024 Issue 100 / 7 with rem_sel=0, tag 3 -> div_ready=0 for 33 cycles; div_cdb_req=1 at accept+33 with data 14 and tag 3; grant -> IDLE next edge.
REQ-025 Issue 100 / 7 with rem_sel=1 -> data 2; hold grant low 5 cycles -> req and outputs stable throughout, then clear one edge after grant.
REQ-026 Issue 0x1234 / 0 -> quotient 0xFFFFFFFF; with rem_sel=1 -> remainder 0x1234.
REQ-027 rob_r_ptr=30, held tag 2, cdb_rob_tag 1 at BUSY cycle 10 -> IDLE next cycle, no req ever; repeat with cdb_rob_tag 4 -> completes normally.
REQ-028 In DONE, assert grant and junior flush together -> dropped; issue with a junior tag during flush -> not accepted.
REQ-029 Assert reset=0 at BUSY cycle 20 -> all outputs 0 immediately; after release, div_ready=1 and no stale req appears.

Source files
------------

// File: rtl/div_exe_unit.sv
// Non-pipelined unsigned restoring divider execution unit with ROB-tag flush
// support and a CDB request/grant handshake.
module div_exe_unit #(
    parameter int DATA_WIDTH    = 32,
    parameter int ROB_TAG_WIDTH = 5,
    parameter int PID_WIDTH     = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     iu_div_issue,
    output logic                     div_ready,
    input  logic [DATA_WIDTH-1:0]    iss_rs_data,
    input  logic [DATA_WIDTH-1:0]    iss_rt_data,
    input  logic                     iss_rem_sel,
    input  logic [ROB_TAG_WIDTH-1:0] iss_rob_tag,
    input  logic [PID_WIDTH-1:0]     iss_rd_pid,
    input  logic                     iss_reg_wr,
    input  logic                     cdb_flush,
    input  logic [ROB_TAG_WIDTH-1:0] cdb_rob_tag,
    input  logic [ROB_TAG_WIDTH-1:0] rob_r_ptr,
    output logic                     div_cdb_req,
    input  logic                     cdb_div_grant,
    output logic [DATA_WIDTH-1:0]    div_cdb_data,
    output logic [ROB_TAG_WIDTH-1:0] div_cdb_rob_tag,
    output logic [PID_WIDTH-1:0]     div_cdb_rd_pid,
    output logic                     div_cdb_reg_wr
);
    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                   state;
    logic [CNT_W-1:0]         cnt;
    logic [DATA_WIDTH-1:0]    divisor;
    logic [DATA_WIDTH-1:0]    quo;
    logic [DATA_WIDTH-1:0]    rem;
    logic                     rem_sel;
    logic [ROB_TAG_WIDTH-1:0] tag;
    logic [PID_WIDTH-1:0]     pid;
    logic                     reg_wr;

    logic [DATA_WIDTH:0]      shifted;
    logic                     ge;
    logic [DATA_WIDTH-1:0]    rem_next;
    logic [DATA_WIDTH-1:0]    quo_next;
    logic                     flush_held;
    logic                     accept;

    // Age is measured as distance from the ROB head so wrap-around compares correctly.
    function automatic logic is_junior(input logic [ROB_TAG_WIDTH-1:0] t,
                                       input logic [ROB_TAG_WIDTH-1:0] ftag,
                                       input logic [ROB_TAG_WIDTH-1:0] head);
        logic [ROB_TAG_WIDTH-1:0] d_t;
        logic [ROB_TAG_WIDTH-1:0] d_f;
        d_t = t - head;
        d_f = ftag - head;
        return d_t >= d_f;
    endfunction

    // Partial remainder stays below the divisor, so the subtraction fits in DATA_WIDTH bits.
    always_comb begin
        shifted  = {rem, quo[DATA_WIDTH-1]};
        ge       = shifted >= {1'b0, divisor};
        rem_next = ge ? (shifted[DATA_WIDTH-1:0] - divisor) : shifted[DATA_WIDTH-1:0];
        quo_next = {quo[DATA_WIDTH-2:0], ge};
    end

    assign flush_held = cdb_flush && is_junior(tag, cdb_rob_tag, rob_r_ptr);
    assign accept     = iu_div_issue && div_ready &&
                        !(cdb_flush && is_junior(iss_rob_tag, cdb_rob_tag, rob_r_ptr));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            cnt             <= '0;
            divisor         <= '0;
            quo             <= '0;
            rem             <= '0;
            rem_sel         <= 1'b0;
            tag             <= '0;
            pid             <= '0;
            reg_wr          <= 1'b0;
            div_ready       <= 1'b1;
            div_cdb_req     <= 1'b0;
            div_cdb_data    <= '0;
            div_cdb_rob_tag <= '0;
            div_cdb_rd_pid  <= '0;
            div_cdb_reg_wr  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= BUSY;
                        div_ready <= 1'b0;
                        cnt       <= '0;
                        rem       <= '0;
                        quo       <= iss_rs_data;
                        divisor   <= iss_rt_data;
                        rem_sel   <= iss_rem_sel;
                        tag       <= iss_rob_tag;
                        pid       <= iss_rd_pid;
                        reg_wr    <= iss_reg_wr;
                    end
                end
                BUSY: begin
                    if (flush_held) begin
                        state     <= IDLE;
                        div_ready <= 1'b1;
                    end else if (cnt == CNT_W'(DATA_WIDTH)) begin
                        // Final cycle only loads the result registers.
                        state           <= DONE;
                        div_cdb_req     <= 1'b1;
                        div_cdb_data    <= rem_sel ? rem : quo;
                        div_cdb_rob_tag <= tag;
                        div_cdb_rd_pid  <= pid;
                        div_cdb_reg_wr  <= reg_wr;
                    end else begin
                        rem <= rem_next;
                        quo <= quo_next;
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (flush_held || cdb_div_grant) begin
                        state           <= IDLE;
                        div_ready       <= 1'b1;
                        div_cdb_req     <= 1'b0;
                        div_cdb_data    <= '0;
                        div_cdb_rob_tag <= '0;
                        div_cdb_rd_pid  <= '0;
                        div_cdb_reg_wr  <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    div_ready   <= 1'b1;
                    div_cdb_req <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div_exe_unit.sv
// Directed bench for div_exe_unit: latency, results, divide-by-zero, flush and reset.
module tb_div_exe_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        iu_div_issue;
    logic        div_ready;
    logic [31:0] iss_rs_data;
    logic [31:0] iss_rt_data;
    logic        iss_rem_sel;
    logic [4:0]  iss_rob_tag;
    logic [5:0]  iss_rd_pid;
    logic        iss_reg_wr;
    logic        cdb_flush;
    logic [4:0]  cdb_rob_tag;
    logic [4:0]  rob_r_ptr;
    logic        div_cdb_req;
    logic        cdb_div_grant;
    logic [31:0] div_cdb_data;
    logic [4:0]  div_cdb_rob_tag;
    logic [5:0]  div_cdb_rd_pid;
    logic        div_cdb_reg_wr;

    int nchk = 0;
    int nerr = 0;
    int lat;
    int reqs;

    div_exe_unit dut (
        .clk(clk), .reset(reset), .iu_div_issue(iu_div_issue), .div_ready(div_ready),
        .iss_rs_data(iss_rs_data), .iss_rt_data(iss_rt_data), .iss_rem_sel(iss_rem_sel),
        .iss_rob_tag(iss_rob_tag), .iss_rd_pid(iss_rd_pid), .iss_reg_wr(iss_reg_wr),
        .cdb_flush(cdb_flush), .cdb_rob_tag(cdb_rob_tag), .rob_r_ptr(rob_r_ptr),
        .div_cdb_req(div_cdb_req), .cdb_div_grant(cdb_div_grant),
        .div_cdb_data(div_cdb_data), .div_cdb_rob_tag(div_cdb_rob_tag),
        .div_cdb_rd_pid(div_cdb_rd_pid), .div_cdb_reg_wr(div_cdb_reg_wr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic rs,
                         input logic [4:0] t, input logic [5:0] p, input logic w);
        iss_rs_data  = a;
        iss_rt_data  = b;
        iss_rem_sel  = rs;
        iss_rob_tag  = t;
        iss_rd_pid   = p;
        iss_reg_wr   = w;
        iu_div_issue = 1'b1;
        step();
        iu_div_issue = 1'b0;
    endtask

    task automatic wait_req(output int n);
        n = 0;
        while (div_cdb_req !== 1'b1 && n < 200) begin
            step();
            n++;
        end
    endtask

    task automatic grant();
        cdb_div_grant = 1'b1;
        step();
        cdb_div_grant = 1'b0;
    endtask

    task automatic run(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic rs, input logic [31:0] exp);
        issue(a, b, rs, 5'd1, 6'd1, 1'b1);
        wait_req(lat);
        chk({name, "_lat"}, lat, 33);
        chk({name, "_data"}, div_cdb_data, exp);
        grant();
        chk({name, "_clr"}, div_cdb_req, 1'b0);
    endtask

    initial begin
        reset = 1'b0;
        iu_div_issue = 1'b0; iss_rs_data = '0; iss_rt_data = '0; iss_rem_sel = 1'b0;
        iss_rob_tag = '0; iss_rd_pid = '0; iss_reg_wr = 1'b0;
        cdb_flush = 1'b0; cdb_rob_tag = '0; rob_r_ptr = '0; cdb_div_grant = 1'b0;
        #12;
        chk("rst_ready", div_ready, 1'b1);
        chk("rst_req", div_cdb_req, 1'b0);
        chk("rst_data", div_cdb_data, 32'h0);
        chk("rst_tag", div_cdb_rob_tag, 5'd0);
        chk("rst_pid", div_cdb_rd_pid, 6'd0);
        chk("rst_wr", div_cdb_reg_wr, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // 100/7 quotient, accepted on first edge after reset release
        issue(32'd100, 32'd7, 1'b0, 5'd3, 6'd5, 1'b1);
        chk("q_busy_ready", div_ready, 1'b0);
        reqs = 0;
        for (int i = 1; i < 33; i++) begin
            step();
            if (div_cdb_req === 1'b1 || div_ready === 1'b1) reqs++;
        end
        chk("q_early_req", reqs, 0);
        step();
        chk("q_req", div_cdb_req, 1'b1);
        chk("q_data", div_cdb_data, 32'd14);
        chk("q_tag", div_cdb_rob_tag, 5'd3);
        chk("q_pid", div_cdb_rd_pid, 6'd5);
        chk("q_wr", div_cdb_reg_wr, 1'b1);
        grant();
        chk("q_req_clr", div_cdb_req, 1'b0);
        chk("q_idle", div_ready, 1'b1);

        // 100/7 remainder with grant held low
        issue(32'd100, 32'd7, 1'b1, 5'd9, 6'd12, 1'b0);
        wait_req(lat);
        chk("r_lat", lat, 33);
        reqs = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (div_cdb_req !== 1'b1 || div_cdb_data !== 32'd2 || div_cdb_rob_tag !== 5'd9 ||
                div_cdb_rd_pid !== 6'd12 || div_cdb_reg_wr !== 1'b0) reqs++;
        end
        chk("r_hold_unstable", reqs, 0);
        chk("r_data", div_cdb_data, 32'd2);
        grant();
        chk("r_req_clr", div_cdb_req, 1'b0);

        run("dz_q", 32'h1234, 32'h0, 1'b0, 32'hFFFF_FFFF);
        run("dz_r", 32'h1234, 32'h0, 1'b1, 32'h1234);
        run("big_q", 32'hFFFF_FFFF, 32'h10, 1'b0, 32'h0FFF_FFFF);
        run("big_r", 32'hFFFF_FFFF, 32'h10, 1'b1, 32'hF);
        run("msb_q", 32'h8000_0000, 32'd3, 1'b0, 32'h2AAA_AAAA);
        run("msb_r", 32'h8000_0000, 32'd3, 1'b1, 32'd2);
        run("small_q", 32'd5, 32'd9, 1'b0, 32'd0);
        run("small_r", 32'd5, 32'd9, 1'b1, 32'd5);

        // Junior flush during BUSY (wrap-around ROB pointer)
        rob_r_ptr = 5'd30;
        issue(32'd100, 32'd7, 1'b0, 5'd2, 6'd1, 1'b1);
        for (int i = 0; i < 9; i++) step();
        cdb_flush = 1'b1; cdb_rob_tag = 5'd1;
        step();
        cdb_flush = 1'b0;
        chk("fj_idle", div_ready, 1'b1);
        chk("fj_req", div_cdb_req, 1'b0);
        reqs = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (div_cdb_req === 1'b1) reqs++;
        end
        chk("fj_no_req", reqs, 0);

        // Senior flush during BUSY leaves the instruction alone
        issue(32'd100, 32'd7, 1'b0, 5'd2, 6'd1, 1'b1);
        for (int i = 0; i < 9; i++) step();
        cdb_flush = 1'b1; cdb_rob_tag = 5'd4;
        step();
        cdb_flush = 1'b0;
        chk("fs_busy", div_ready, 1'b0);
        wait_req(lat);
        chk("fs_lat", lat, 23);
        chk("fs_data", div_cdb_data, 32'd14);
        chk("fs_tag", div_cdb_rob_tag, 5'd2);
        grant();

        // Grant and junior flush together in DONE; issue attempt is ignored too
        rob_r_ptr = 5'd0;
        issue(32'd50, 32'd5, 1'b0, 5'd7, 6'd2, 1'b1);
        wait_req(lat);
        chk("gf_lat", lat, 33);
        cdb_div_grant = 1'b1; cdb_flush = 1'b1; cdb_rob_tag = 5'd5;
        iu_div_issue = 1'b1; iss_rob_tag = 5'd6;
        step();
        cdb_div_grant = 1'b0; iu_div_issue = 1'b0;
        chk("gf_req", div_cdb_req, 1'b0);
        chk("gf_idle", div_ready, 1'b1);
        // Junior issue during flush is refused
        cdb_rob_tag = 5'd8;
        issue(32'd50, 32'd5, 1'b0, 5'd9, 6'd2, 1'b1);
        chk("ji_refused", div_ready, 1'b1);
        // Senior issue during flush is accepted
        issue(32'd50, 32'd5, 1'b0, 5'd3, 6'd4, 1'b1);
        cdb_flush = 1'b0;
        chk("si_accept", div_ready, 1'b0);
        wait_req(lat);
        chk("si_lat", lat, 33);
        chk("si_data", div_cdb_data, 32'd10);
        chk("si_tag", div_cdb_rob_tag, 5'd3);
        grant();

        // Reset mid-operation
        issue(32'd100, 32'd7, 1'b0, 5'd4, 6'd3, 1'b1);
        for (int i = 0; i < 19; i++) step();
        #2;
        reset = 1'b0;
        #1;
        chk("mr_ready", div_ready, 1'b1);
        chk("mr_req", div_cdb_req, 1'b0);
        chk("mr_data", div_cdb_data, 32'h0);
        step();
        @(negedge clk);
        reset = 1'b1;
        reqs = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (div_cdb_req === 1'b1 || div_ready !== 1'b1) reqs++;
        end
        chk("mr_no_stale", reqs, 0);
        run("post_rst", 32'd100, 32'd7, 1'b0, 32'd14);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
